mem_pipe_stage: RTL and testbench

MEM_PIPE_STAGE -- requirements
Module: mem_pipe_stage

---
 rtl/mem_pipe_stage.sv | 179 +++++++++++++++++
 tb/tb_mem_pipe_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_pipe_stage.sv
// Memory-access pipeline stage: registers one instruction, waits for the data
// SRAM response on loads, formats load data and resolves exception outputs.
module mem_pipe_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter int          EXC_W    = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op,
  input  logic [31:0]      pc,
  input  logic [31:0]      aluout,
  input  logic [31:0]      rt_value,
  input  logic [4:0]       writereg,
  input  logic             regwrite,
  input  logic             memtoreg,
  input  logic             cp0_write,
  input  logic             is_in_slot,
  input  logic [EXC_W-1:0] exception_code,
  input  logic [31:0]      badaddr,
  input  logic             data_ok,
  input  logic [31:0]      rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic [31:0]      pc_out,
  output logic [4:0]       writereg_out,
  output logic             regwrite_out,
  output logic             cp0_write_out,
  output logic             is_in_slot_out,
  output logic [31:0]      excepttype,
  output logic [31:0]      badaddr_out
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;

  typedef enum logic [1:0] {EMPTY, WAIT, FULL} state_t;

  typedef struct packed {
    logic [5:0]       op;
    logic [31:0]      pc;
    logic [31:0]      aluout;
    logic [31:0]      rt;
    logic [4:0]       writereg;
    logic             regwrite;
    logic             cp0_write;
    logic             is_in_slot;
    logic [EXC_W-1:0] exc;
    logic [31:0]      badaddr;
    logic             misalign;
  } entry_t;

  function automatic entry_t idle_entry();
    idle_entry    = '0;
    idle_entry.pc = RESET_PC;
  endfunction

  state_t      state;
  logic        drop_pending;
  entry_t      ent;
  entry_t      new_ent;
  logic        accept;
  logic        is_load_in;
  logic        misalign_in;
  logic        exc_pending_in;
  logic [31:0] load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [1:0]  addr_r;

  // Load classification is by opcode alone; memtoreg carries no extra meaning here.
  logic unused_memtoreg;
  assign unused_memtoreg = memtoreg;

  assign in_ready  = ~drop_pending & ((state == EMPTY) | ((state == FULL) & out_ready));
  assign out_valid = (state == FULL);
  assign accept    = in_valid & in_ready & ~flush;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    new_ent        = '0;
    is_load_in     = op inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR};
    misalign_in    = ((op == OP_LH || op == OP_LHU) && aluout[0]) ||
                     ((op == OP_LW) && (aluout[1:0] != 2'b00));
    exc_pending_in = (exception_code != '0) || (pc[1:0] != 2'b00) || misalign_in;

    new_ent.op         = op;
    new_ent.pc         = pc;
    new_ent.aluout     = aluout;
    new_ent.rt         = rt_value;
    new_ent.writereg   = writereg;
    new_ent.regwrite   = regwrite & ~exc_pending_in;
    new_ent.cp0_write  = cp0_write & ~exc_pending_in;
    new_ent.is_in_slot = is_in_slot;
    new_ent.exc        = exception_code;
    new_ent.exc[6]     = exception_code[6] | misalign_in;
    new_ent.badaddr    = badaddr;
    new_ent.misalign   = misalign_in;
  end

  // Little-endian byte lanes; LWL/LWR merge the partial word into rt.
  always_comb begin
    addr_r    = ent.aluout[1:0];
    byte_sel  = rdata[{addr_r, 3'b000} +: 8];
    half_sel  = addr_r[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (ent.op)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'd0, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'd0, half_sel};
      OP_LWL:  load_data = (rdata << {~addr_r, 3'b000}) |
                           (ent.rt & (32'hFFFF_FFFF >> ({1'b0, addr_r, 3'b000} + 6'd8)));
      OP_LWR:  load_data = (rdata >> {addr_r, 3'b000}) |
                           (ent.rt & ~(32'hFFFF_FFFF >> {addr_r, 3'b000}));
      default: load_data = rdata;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!resetn) begin
      state        <= EMPTY;
      drop_pending <= 1'b0;
      ent          <= idle_entry();
      result       <= '0;
    end else if (flush) begin
      state        <= EMPTY;
      // A flushed load still has a response in flight that must be swallowed.
      drop_pending <= (state == WAIT) | (drop_pending & ~data_ok);
      ent          <= idle_entry();
      result       <= '0;
    end else begin
      if (drop_pending && data_ok) drop_pending <= 1'b0;
      if (accept) begin
        ent    <= new_ent;
        result <= aluout;
        state  <= (is_load_in && !exc_pending_in) ? WAIT : FULL;
      end else if (state == WAIT && data_ok) begin
        result <= load_data;
        state  <= FULL;
      end else if (state == FULL && out_ready) begin
        state  <= EMPTY;
      end
    end
  end

  assign pc_out         = ent.pc;
  assign writereg_out   = ent.writereg;
  assign regwrite_out   = ent.regwrite;
  assign cp0_write_out  = ent.cp0_write;
  assign is_in_slot_out = ent.is_in_slot;
  assign badaddr_out    = (ent.pc[1:0] != 2'b00) ? ent.pc :
                          ent.misalign ? ent.aluout : ent.badaddr;

  // Exception bits: 7 int, 6 adel, 5 ades, 4 ov, 3 ri, 2 sys, 1 brk, 0 eret.
  always_comb begin
    excepttype = 32'd0;
    if (out_valid) begin
      if (ent.exc[7])                                excepttype = 32'h1;
      else if (ent.exc[6] || ent.pc[1:0] != 2'b00)   excepttype = 32'h4;
      else if (ent.exc[5])                           excepttype = 32'h5;
      else if (ent.exc[2])                           excepttype = 32'h8;
      else if (ent.exc[1])                           excepttype = 32'h9;
      else if (ent.exc[0])                           excepttype = 32'hE;
      else if (ent.exc[3])                           excepttype = 32'hA;
      else if (ent.exc[4])                           excepttype = 32'hC;
    end
  end

endmodule

// File: tb/tb_mem_pipe_stage.sv
// Directed, scoreboard-based bench for mem_pipe_stage.
module tb_mem_pipe_stage;
  localparam int EXC_W = 8;
  localparam logic [31:0] RST_PC = 32'hBFC00000;
  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LWL = 6'h22, LW = 6'h23,
                         LBU = 6'h24, LHU = 6'h25, LWR = 6'h26, ADDIU = 6'h09;

  logic clk = 1'b0, resetn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [5:0] op;
  logic [31:0] pc, aluout, rt_value, badaddr, rdata;
  logic [4:0] writereg;
  logic regwrite, memtoreg, cp0_write, is_in_slot, data_ok;
  logic [EXC_W-1:0] exception_code;
  logic [31:0] result, pc_out, excepttype, badaddr_out;
  logic [4:0] writereg_out;
  logic regwrite_out, cp0_write_out, is_in_slot_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] result, pc, excepttype, badaddr;
    logic [4:0]  writereg;
    logic        regwrite, cp0_write, is_in_slot;
  } exp_t;
  exp_t sb[$];

  mem_pipe_stage #(.RESET_PC(RST_PC), .EXC_W(EXC_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .pc(pc), .aluout(aluout), .rt_value(rt_value), .writereg(writereg),
    .regwrite(regwrite), .memtoreg(memtoreg), .cp0_write(cp0_write), .is_in_slot(is_in_slot),
    .exception_code(exception_code), .badaddr(badaddr), .data_ok(data_ok), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .pc_out(pc_out),
    .writereg_out(writereg_out), .regwrite_out(regwrite_out), .cp0_write_out(cp0_write_out),
    .is_in_slot_out(is_in_slot_out), .excepttype(excepttype), .badaddr_out(badaddr_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] o, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] rt, input logic [EXC_W-1:0] ec, input logic [31:0] ba);
    op = o; pc = p; aluout = a; rt_value = rt; exception_code = ec; badaddr = ba;
    writereg = p[6:2]; regwrite = 1'b1; cp0_write = 1'b0; is_in_slot = p[2];
    memtoreg = (o[5:3] == 3'b100); in_valid = 1'b1;
  endtask

  task automatic push(input logic [31:0] res, input logic [31:0] p, input logic [31:0] et,
                      input logic [31:0] ba, input logic rw);
    exp_t e;
    e.result = res; e.pc = p; e.excepttype = et; e.badaddr = ba;
    e.writereg = p[6:2]; e.regwrite = rw; e.cp0_write = 1'b0; e.is_in_slot = p[2];
    sb.push_back(e);
  endtask

  task automatic accept_one(input string tag);
    #1 check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s.scoreboard: observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".result"}, result, e.result);
      check({tag, ".pc_out"}, pc_out, e.pc);
      check({tag, ".excepttype"}, excepttype, e.excepttype);
      check({tag, ".badaddr_out"}, badaddr_out, e.badaddr);
      check({tag, ".writereg_out"}, {27'd0, writereg_out}, {27'd0, e.writereg});
      check({tag, ".regwrite_out"}, {31'd0, regwrite_out}, {31'd0, e.regwrite});
      check({tag, ".cp0_write_out"}, {31'd0, cp0_write_out}, {31'd0, e.cp0_write});
      check({tag, ".is_in_slot_out"}, {31'd0, is_in_slot_out}, {31'd0, e.is_in_slot});
    end
  endtask

  // Accept a load, hold the response for 'lat' cycles, then expect output one cycle later.
  task automatic do_load(input string tag, input logic [5:0] o, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] rt, input int lat,
                         input logic [31:0] rd, input logic [31:0] exp_res);
    drive(o, p, a, rt, '0, 32'h0);
    push(exp_res, p, 32'd0, 32'd0, 1'b1);
    accept_one(tag);
    check({tag, ".wait_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".wait_ready"}, {31'd0, in_ready}, 32'd0);
    repeat (lat) step();
    data_ok = 1'b1; rdata = rd;
    step();
    data_ok = 1'b0;
    check_out(tag);
    step();
  endtask

  task automatic exc_alu(input string tag, input logic [31:0] p, input logic [EXC_W-1:0] ec,
                         input logic [31:0] exp_type, input logic [31:0] exp_bad);
    drive(ADDIU, p, 32'h0000_1234, 32'h0, ec, 32'h0000_9999);
    cp0_write = 1'b1;
    push(32'h0000_1234, p, exp_type, exp_bad, 1'b0);
    accept_one(tag);
    check_out(tag);
    step();
  endtask

  typedef struct { logic [7:0] ec; logic [31:0] et; } exc_vec_t;
  exc_vec_t exc_tab[10] = '{
    '{8'h02, 32'h9}, '{8'h01, 32'hE}, '{8'h08, 32'hA}, '{8'h10, 32'hC}, '{8'h04, 32'h8},
    '{8'h20, 32'h5}, '{8'hC4, 32'h1}, '{8'h44, 32'h4}, '{8'h18, 32'hA}, '{8'h06, 32'h8}
  };

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; data_ok = 1'b0;
    rdata = '0; op = '0; pc = '0; aluout = '0; rt_value = '0; writereg = '0;
    regwrite = 1'b0; memtoreg = 1'b0; cp0_write = 1'b0; is_in_slot = 1'b0;
    exception_code = '0; badaddr = '0;
    repeat (2) step();
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.excepttype", excepttype, 32'd0);
    check("rst.pc_out", pc_out, RST_PC);
    check("rst.result", result, 32'd0);
    check("rst.badaddr_out", badaddr_out, 32'd0);
    check("rst.regwrite_out", {31'd0, regwrite_out}, 32'd0);
    resetn = 1'b1;
    step();

    // Loads and formatting
    do_load("lb_a2",  LB,  32'h0040_0000, 32'h1000_0002, 32'h0, 3, 32'h12F4_5678, 32'hFFFF_FFF4);
    do_load("lbu_a1", LBU, 32'h0040_0004, 32'h1000_0001, 32'h0, 1, 32'h12F4_5678, 32'h0000_0056);
    do_load("lb_a3",  LB,  32'h0040_0008, 32'h1000_0003, 32'h0, 0, 32'h12F4_5678, 32'h0000_0012);
    do_load("lh_a2",  LH,  32'h0040_000C, 32'h1000_0002, 32'h0, 2, 32'h8001_1234, 32'hFFFF_8001);
    do_load("lhu_a0", LHU, 32'h0040_0010, 32'h1000_0000, 32'h0, 1, 32'h8001_1234, 32'h0000_1234);
    do_load("lhu_a2", LHU, 32'h0040_0014, 32'h1000_0002, 32'h0, 1, 32'h8001_1234, 32'h0000_8001);
    do_load("lw_a0",  LW,  32'h0040_0018, 32'h1000_0000, 32'h0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D);
    do_load("lwl_a1", LWL, 32'h0040_001C, 32'h1000_0001, 32'h1122_3344, 1, 32'hAABB_CCDD, 32'hCCDD_3344);
    do_load("lwr_a1", LWR, 32'h0040_0020, 32'h1000_0001, 32'h1122_3344, 1, 32'hAABB_CCDD, 32'h11AA_BBCC);

    // Misaligned loads: no WAIT, adel reported, aluout as bad address
    drive(LW, 32'h0040_0040, 32'h1000_0002, 32'h0, '0, 32'hDEAD_0000);
    push(32'h1000_0002, 32'h0040_0040, 32'h4, 32'h1000_0002, 1'b0);
    accept_one("lw_mis");
    check_out("lw_mis");
    step();
    drive(LH, 32'h0040_0044, 32'h1000_0001, 32'h0, '0, 32'hDEAD_0000);
    push(32'h1000_0001, 32'h0040_0044, 32'h4, 32'h1000_0001, 1'b0);
    accept_one("lh_mis");
    check_out("lh_mis");
    step();

    // Exception priority, misaligned pc, excepting load skips WAIT
    foreach (exc_tab[i])
      exc_alu($sformatf("exc_%02h", exc_tab[i].ec), 32'h0040_0050 + 32'(4 * i),
              exc_tab[i].ec, exc_tab[i].et, 32'h0000_9999);
    exc_alu("pc_mis", 32'h0040_0062, '0, 32'h4, 32'h0040_0062);
    drive(LW, 32'h0040_0080, 32'h1000_0000, 32'h0, 8'h20, 32'h0000_7777);
    push(32'h1000_0000, 32'h0040_0080, 32'h5, 32'h0000_7777, 1'b0);
    accept_one("lw_ades");
    check_out("lw_ades");
    step();

    // Back-to-back ALU ops, one result per cycle
    for (int i = 0; i < 4; i++) begin
      drive(ADDIU, 32'h0040_0100 + 32'(4 * i), 32'h1111 * 32'(i + 1), 32'h0, '0, 32'h0);
      push(32'h1111 * 32'(i + 1), 32'h0040_0100 + 32'(4 * i), 32'd0, 32'd0, 1'b1);
      #1 check("b2b.in_ready", {31'd0, in_ready}, 32'd1);
      step();
      check_out("b2b");
    end
    in_valid = 1'b0;
    step();

    // Stall: outputs hold, in_ready low, stray data_ok ignored
    out_ready = 1'b0;
    drive(ADDIU, 32'h0040_0200, 32'hAAAA_0001, 32'h0, '0, 32'h0);
    push(32'hAAAA_0001, 32'h0040_0200, 32'd0, 32'd0, 1'b1);
    accept_one("hold_a");
    drive(ADDIU, 32'h0040_0204, 32'hBBBB_0002, 32'h0, '0, 32'h0);
    data_ok = 1'b1; rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      #1 check("hold.in_ready", {31'd0, in_ready}, 32'd0);
      check("hold.result", result, 32'hAAAA_0001);
      check("hold.pc_out", pc_out, 32'h0040_0200);
      check("hold.out_valid", {31'd0, out_valid}, 32'd1);
      step();
    end
    data_ok = 1'b0;
    out_ready = 1'b1;
    #1 check("release.in_ready", {31'd0, in_ready}, 32'd1);
    check_out("hold_a");
    push(32'hBBBB_0002, 32'h0040_0204, 32'd0, 32'd0, 1'b1);
    step();
    in_valid = 1'b0;
    check_out("hold_b");
    step();

    // Flush during WAIT: response dropped, in_ready low until it arrives
    drive(LW, 32'h0040_0300, 32'h1000_0100, 32'h0, '0, 32'h0);
    accept_one("fl_wait");
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl.out_valid", {31'd0, out_valid}, 32'd0);
    check("fl.pc_out", pc_out, RST_PC);
    check("fl.result", result, 32'd0);
    check("fl.in_ready", {31'd0, in_ready}, 32'd0);
    drive(ADDIU, 32'h0040_0304, 32'h0000_0BAD, 32'h0, '0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("fl.blocked_ready", {31'd0, in_ready}, 32'd0);
      check("fl.blocked_valid", {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b0;
    data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
    step();
    data_ok = 1'b0;
    check("fl.drop_valid", {31'd0, out_valid}, 32'd0);
    check("fl.drop_ready", {31'd0, in_ready}, 32'd1);
    do_load("fl_next", LW, 32'h0040_0308, 32'h1000_0104, 32'h0, 1, 32'h55AA_55AA, 32'h55AA_55AA);

    // Flush together with in_valid accepts nothing
    drive(ADDIU, 32'h0040_0400, 32'h0000_4444, 32'h0, '0, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_in.out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_in.pc_out", pc_out, RST_PC);
    step();
    check("fl_in.out_valid2", {31'd0, out_valid}, 32'd0);

    // Flush in FULL clears outputs without blocking input
    out_ready = 1'b0;
    drive(ADDIU, 32'h0040_0410, 32'h0000_5555, 32'h0, '0, 32'h0);
    accept_one("fl_full");
    check("fl_full.pre_valid", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b1;
    check("fl_full.out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_full.result", result, 32'd0);
    check("fl_full.regwrite", {31'd0, regwrite_out}, 32'd0);
    check("fl_full.in_ready", {31'd0, in_ready}, 32'd1);

    // Reset mid-WAIT: late response ignored
    drive(LW, 32'h0040_0500, 32'h1000_0200, 32'h0, '0, 32'h0);
    accept_one("rst_wait");
    step();
    #2 resetn = 1'b0;
    #1 check("rstw.out_valid", {31'd0, out_valid}, 32'd0);
    check("rstw.pc_out", pc_out, RST_PC);
    check("rstw.in_ready", {31'd0, in_ready}, 32'd1);
    step();
    resetn = 1'b1;
    step();
    data_ok = 1'b1; rdata = 32'h7777_7777;
    step();
    data_ok = 1'b0;
    check("rstw.late_valid", {31'd0, out_valid}, 32'd0);
    check("rstw.late_ready", {31'd0, in_ready}, 32'd1);
    check("rstw.late_result", result, 32'd0);
    do_load("rstw_next", LBU, 32'h0040_0504, 32'h1000_0003, 32'h0, 1, 32'hA1B2_C3D4, 32'h0000_00A1);

    check("sb.left", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
